seq_booth_multiplier: RTL and testbench

SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

---
 rtl/seq_booth_multiplier.sv | 64 ++++++
 tb/tb_seq_booth_multiplier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: sequential radix-2 Booth multiplier, one step per cycle,
// fixed WIDTH+3 cycle latency, signed or unsigned operands.
module seq_booth_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    localparam int CW = $clog2(WIDTH + 2);
    state_t         state;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] acc, q, m, sum;
    logic           q_1;
    // One extra operand bit lets full-range unsigned values ride a signed datapath
    always_comb sum = (q[0] & ~q_1) ? acc - m : (~q[0] & q_1) ? acc + m : acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {sgn & a[WIDTH-1], a};
                        q     <= {sgn & b[WIDTH-1], b};
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    {acc, q, q_1} <= {sum[WIDTH], sum, q};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH)) state <= FIN;
                end
                FIN: begin
                    p     <= {acc[WIDTH-2:0], q};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: directed and randomized checks of the Booth multiplier
// against an integer-arithmetic reference model.
module tb_seq_booth_multiplier;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sgn;
    logic [3:0] a, b;
    logic       busy, done;
    logic [7:0] p;
    int         checks = 0;
    int         failures = 0;

    seq_booth_multiplier #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .p(p)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic s, input logic [3:0] x, input logic [3:0] y);
        int r;
        if (s) r = int'($signed(x)) * int'($signed(y));
        else   r = int'(x) * int'(y);
        return r[7:0];
    endfunction

    task automatic issue(input logic s, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        sgn = s; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen; bounded.
    task automatic wait_done(output int cyc, output logic ok);
        cyc = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_latency;
        logic [7:0] p0;
        p0 = p;
        issue(1'b1, 4'b1001, 4'b1001);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || p !== p0) begin
                failures++;
                $display("FAIL latency_busy[%0d]: busy=%b done=%b p=%h, want 1 0 %h", i, busy, done, p, p0);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || p !== 8'h31) begin
            failures++;
            $display("FAIL latency_done: done=%b busy=%b p=%h, want 1 0 31", done, busy, p);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || p !== 8'h31) begin
            failures++;
            $display("FAIL latency_pulse: done=%b p=%h, want 0 31", done, p);
        end
    endtask

    task automatic test_directed;
        logic       s_t[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
        logic [3:0] a_t[8] = '{4'h1, 4'h9, 4'h8, 4'h0, 4'h0, 4'h8, 4'hF, 4'hF};
        logic [3:0] b_t[8] = '{4'hD, 4'h7, 4'h8, 4'hD, 4'h8, 4'h0, 4'hF, 4'hF};
        logic [7:0] e_t[8] = '{8'hFD, 8'hCF, 8'h40, 8'h00, 8'h00, 8'h00, 8'hE1, 8'h01};
        int cyc;
        logic ok;
        for (int i = 0; i < 8; i++) begin
            issue(s_t[i], a_t[i], b_t[i]);
            wait_done(cyc, ok);
            checks++;
            if (!ok || cyc != 6 || p !== e_t[i] || p !== model(s_t[i], a_t[i], b_t[i])) begin
                failures++;
                $display("FAIL directed[%0d] s=%b a=%h b=%h: ok=%b cyc=%0d p=%h, want 1 6 %h",
                         i, s_t[i], a_t[i], b_t[i], ok, cyc, p, e_t[i]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int cyc, ndone;
        logic ok;
        issue(1'b0, 4'd2, 4'd7);
        @(negedge clk);
        start = 1'b1; a = 4'b0011; b = 4'd4; sgn = 1'b1;
        @(negedge clk);
        start = 1'b0; b = 4'd9;
        wait_done(cyc, ok);
        checks++;
        if (!ok || p !== 8'h0E) begin
            failures++;
            $display("FAIL busy_ignore: ok=%b p=%h, want 1 0e", ok, p);
        end
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_extra: dones=%0d busy=%b, want 0 0", ndone, busy);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic ok;
        issue(1'b0, 4'd3, 4'd5);
        wait_done(cyc, ok);
        checks++;
        if (!ok || p !== 8'd15) begin
            failures++;
            $display("FAIL b2b_first: ok=%b p=%h, want 1 0f", ok, p);
        end
        issue(1'b1, 4'hA, 4'h3);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc + 1 != 7 || p !== model(1'b1, 4'hA, 4'h3)) begin
            failures++;
            $display("FAIL b2b_second: ok=%b gap=%0d p=%h, want 1 7 %h", ok, cyc + 1, p, model(1'b1, 4'hA, 4'h3));
        end
    endtask

    task automatic test_async_reset;
        int cyc, ndone;
        logic ok;
        issue(1'b1, 4'd5, 4'd3);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
        end
        #10 rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL async_reset_quiet: active_cycles=%0d, want 0", ndone);
        end
        issue(1'b1, 4'hB, 4'h6);
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc != 6 || p !== model(1'b1, 4'hB, 4'h6)) begin
            failures++;
            $display("FAIL async_reset_after: ok=%b cyc=%0d p=%h, want 1 6 %h", ok, cyc, p, model(1'b1, 4'hB, 4'h6));
        end
    endtask

    task automatic test_random;
        int cyc;
        logic ok, s;
        logic [3:0] x, y;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(1));
            x = 4'($urandom);
            y = 4'($urandom);
            issue(s, x, y);
            wait_done(cyc, ok);
            checks++;
            if (!ok || cyc != 6 || p !== model(s, x, y)) begin
                failures++;
                $display("FAIL random[%0d] s=%b a=%h b=%h: ok=%b cyc=%0d p=%h, want 1 6 %h",
                         i, s, x, y, ok, cyc, p, model(s, x, y));
            end
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_directed;
        test_busy_ignore;
        test_back_to_back;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
